pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_stretch.sv | 165 ++++++++++++++++
 tb/tb_pulse_stretch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//
// Purpose:
//   Stretches single-cycle trigger pulses into a fixed-width output level,
//   followed by an optional mandatory low recovery gap. Triggers that arrive
//   while the stretcher is busy are either ignored (and reported as drops) or,
//   when RETRIGGER is enabled and the output is in its high phase, restart the
//   high phase.
//
// Parameters:
//   HOLD_CYCLES : clocks the output stays high per accepted trigger (1..2^CNT_W-1)
//   GAP_CYCLES  : clocks of forced low recovery after each hold (0..2^CNT_W-1)
//   RETRIGGER   : 1 = a trigger during the high phase restarts the high phase
//   CNT_W       : width of the shared hold/gap down-counter
//
// Ports:
//   clk      : in  - system clock, all state changes on the rising edge
//   rst      : in  - synchronous active-high reset, wins over every other input
//   in       : in  - trigger; every cycle sampled high counts as one trigger
//   out      : out - stretched level, high while the FSM is in HOLD
//   busy     : out - high whenever the FSM is not IDLE
//   drop     : out - one-cycle flag, the cycle after each ignored trigger
//   drop_cnt : out - saturating (255) count of ignored triggers
// -----------------------------------------------------------------------------
module pulse_stretch #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RETRIGGER   = 0,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out,
    output logic       busy,
    output logic       drop,
    output logic [7:0] drop_cnt
);

    // Explicit encoding so the spare code 2'b11 is a known illegal value
    // that the next-state logic steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    // Counter reload values. The counter holds "cycles remaining minus one",
    // so the phase ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1)
                                                             : {CNT_W{1'b0}};
    localparam logic             GAP_EN    = (GAP_CYCLES > 0);
    localparam logic             RETRIG_EN = (RETRIGGER != 0);

    // Saturating increment for the 8-bit drop counter: never wraps to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             drop_r;
    logic             drop_s;
    logic [7:0]       drop_cnt_r;
    logic             cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

    // Next-state, counter and drop-detect logic for the IDLE/HOLD/GAP machine.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        drop_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (in) begin
                    state_s = HOLD;
                    cnt_s   = HOLD_LOAD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = cnt_r;
                end
            end

            HOLD: begin
                if (in && RETRIG_EN) begin
                    // Restart the high phase, even on its final cycle.
                    state_s = HOLD;
                    cnt_s   = HOLD_LOAD;
                end else begin
                    // Without retrigger a trigger here is simply discarded;
                    // the countdown continues untouched.
                    drop_s = in;
                    if (cnt_zero_s) begin
                        if (GAP_EN) begin
                            state_s = GAP;
                            cnt_s   = GAP_LOAD;
                        end else begin
                            state_s = IDLE;
                            cnt_s   = {CNT_W{1'b0}};
                        end
                    end else begin
                        state_s = HOLD;
                        cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            GAP: begin
                // Triggers in the recovery gap are never queued.
                drop_s = in;
                if (cnt_zero_s) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = GAP;
                    cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                drop_s  = 1'b0;
            end
        endcase
    end

    // State, counter and drop bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            drop_r     <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            drop_r  <= drop_s;
            if (drop_s) begin
                drop_cnt_r <= sat_inc8(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Moore outputs: pure decodes of the state register, no path from in.
    assign out      = (state_r == HOLD);
    assign busy     = (state_r != IDLE);
    assign drop     = drop_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch
//
// Directed bench for pulse_stretch with HOLD_CYCLES=4, GAP_CYCLES=2.
// Three instances share clk/rst/trigger:
//   u0 : RETRIGGER=0
//   u1 : RETRIGGER=1
//   u2 : RETRIGGER=0, GAP_CYCLES=0 (no recovery gap)
// Cycle c is the interval after clock edge c; a trigger driven in cycle c is
// sampled at the edge that starts cycle c+1. Outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_pulse_stretch;

    logic       clk;
    logic       rst;
    logic       trig;
    logic       out0, busy0, drop0;
    logic [7:0] cnt0;
    logic       out1, busy1, drop1;
    logic [7:0] cnt1;
    logic       out2, busy2, drop2;
    logic [7:0] cnt2;

    int checks;
    int failures;

    pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in(trig),
        .out(out0), .busy(busy0), .drop(drop0), .drop_cnt(cnt0)
    );

    pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in(trig),
        .out(out1), .busy(busy1), .drop(drop1), .drop_cnt(cnt1)
    );

    pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(0), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .in(trig),
        .out(out2), .busy(busy2), .drop(drop2), .drop_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges; afterwards we sit just past the edge that
    // begins cycle 0 with every instance in IDLE.
    task automatic do_reset();
        rst  = 1'b1;
        trig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks = checks + 4;
        if (out0 !== 1'b0)  begin failures++; $display("FAIL reset_out got=%0b exp=0", out0); end
        if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
        if (drop0 !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0b exp=0", drop0); end
        if (cnt0 !== 8'd0)  begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", cnt0); end
        next_cycle();
    endtask

    // One pulse at cycle 10: high 11-14, gap 15-16, IDLE at 17. u2 has no gap.
    task automatic test_single();
        logic e_out, e_busy, e_busy2;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            trig = (c == 10);
            @(negedge clk);
            e_out   = (c >= 11 && c <= 14);
            e_busy  = (c >= 11 && c <= 16);
            e_busy2 = e_out;
            checks = checks + 7;
            if (out0 !== e_out)   begin failures++; $display("FAIL single_out0 cyc=%0d got=%0b exp=%0b", c, out0, e_out); end
            if (busy0 !== e_busy) begin failures++; $display("FAIL single_busy0 cyc=%0d got=%0b exp=%0b", c, busy0, e_busy); end
            if (drop0 !== 1'b0)   begin failures++; $display("FAIL single_drop0 cyc=%0d got=%0b exp=0", c, drop0); end
            if (out1 !== e_out)   begin failures++; $display("FAIL single_out1 cyc=%0d got=%0b exp=%0b", c, out1, e_out); end
            if (busy1 !== e_busy) begin failures++; $display("FAIL single_busy1 cyc=%0d got=%0b exp=%0b", c, busy1, e_busy); end
            if (out2 !== e_out)   begin failures++; $display("FAIL nogap_out cyc=%0d got=%0b exp=%0b", c, out2, e_out); end
            if (busy2 !== e_busy2) begin failures++; $display("FAIL nogap_busy cyc=%0d got=%0b exp=%0b", c, busy2, e_busy2); end
            next_cycle();
        end
    endtask

    // RETRIGGER=0, pulses at 10 and 12: second one dropped, flagged at 13.
    task automatic test_no_retrigger();
        logic       e_out, e_busy, e_drop;
        logic [7:0] e_cnt;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            trig = (c == 10 || c == 12);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 14);
            e_busy = (c >= 11 && c <= 16);
            e_drop = (c == 13);
            e_cnt  = (c >= 13) ? 8'd1 : 8'd0;
            checks = checks + 4;
            if (out0 !== e_out)   begin failures++; $display("FAIL noretrig_out cyc=%0d got=%0b exp=%0b", c, out0, e_out); end
            if (busy0 !== e_busy) begin failures++; $display("FAIL noretrig_busy cyc=%0d got=%0b exp=%0b", c, busy0, e_busy); end
            if (drop0 !== e_drop) begin failures++; $display("FAIL noretrig_drop cyc=%0d got=%0b exp=%0b", c, drop0, e_drop); end
            if (cnt0 !== e_cnt)   begin failures++; $display("FAIL noretrig_drop_cnt cyc=%0d got=%0d exp=%0d", c, cnt0, e_cnt); end
            next_cycle();
        end
    endtask

    // RETRIGGER=1, pulses at 10 and 13: high 11-17, gap 18-19, IDLE 20.
    task automatic test_retrigger();
        logic e_out, e_busy;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            trig = (c == 10 || c == 13);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 17);
            e_busy = (c >= 11 && c <= 19);
            checks = checks + 4;
            if (out1 !== e_out)   begin failures++; $display("FAIL retrig_out cyc=%0d got=%0b exp=%0b", c, out1, e_out); end
            if (busy1 !== e_busy) begin failures++; $display("FAIL retrig_busy cyc=%0d got=%0b exp=%0b", c, busy1, e_busy); end
            if (drop1 !== 1'b0)   begin failures++; $display("FAIL retrig_drop cyc=%0d got=%0b exp=0", c, drop1); end
            if (cnt1 !== 8'd0)    begin failures++; $display("FAIL retrig_drop_cnt cyc=%0d got=%0d exp=0", c, cnt1); end
            next_cycle();
        end
    endtask

    // RETRIGGER=1, retrigger on the final hold cycle (14): high 11-18.
    task automatic test_retrigger_last();
        logic e_out, e_busy;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            trig = (c == 10 || c == 14);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 18);
            e_busy = (c >= 11 && c <= 20);
            checks = checks + 3;
            if (out1 !== e_out)   begin failures++; $display("FAIL retrig_last_out cyc=%0d got=%0b exp=%0b", c, out1, e_out); end
            if (busy1 !== e_busy) begin failures++; $display("FAIL retrig_last_busy cyc=%0d got=%0b exp=%0b", c, busy1, e_busy); end
            if (drop1 !== 1'b0)   begin failures++; $display("FAIL retrig_last_drop cyc=%0d got=%0b exp=0", c, drop1); end
            next_cycle();
        end
    endtask

    // RETRIGGER=0, in high 10-29: out 11-14, 18-21, 25-28; drops follow
    // every high cycle spent outside IDLE (11-16, 18-23, 25-29).
    task automatic test_continuous();
        logic       e_out, e_drop;
        logic [7:0] e_cnt;
        do_reset();
        e_cnt = 8'd0;
        for (int c = 0; c <= 34; c++) begin
            trig = (c >= 10 && c <= 29);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
            e_drop = (c >= 12 && c <= 17) || (c >= 19 && c <= 24) || (c >= 26 && c <= 30);
            if (e_drop) e_cnt = e_cnt + 8'd1;
            checks = checks + 3;
            if (out0 !== e_out)   begin failures++; $display("FAIL cont_out cyc=%0d got=%0b exp=%0b", c, out0, e_out); end
            if (drop0 !== e_drop) begin failures++; $display("FAIL cont_drop cyc=%0d got=%0b exp=%0b", c, drop0, e_drop); end
            if (cnt0 !== e_cnt)   begin failures++; $display("FAIL cont_drop_cnt cyc=%0d got=%0d exp=%0d", c, cnt0, e_cnt); end
            next_cycle();
        end
        checks++;
        if (cnt0 !== 8'd17) begin failures++; $display("FAIL cont_drop_total got=%0d exp=17", cnt0); end
    endtask

    // RETRIGGER=1, in high 10-19: last trigger at 19 -> high through 23.
    task automatic test_continuous_retrig();
        logic e_out, e_busy;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            trig = (c >= 10 && c <= 19);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 23);
            e_busy = (c >= 11 && c <= 25);
            checks = checks + 3;
            if (out1 !== e_out)   begin failures++; $display("FAIL cont_retrig_out cyc=%0d got=%0b exp=%0b", c, out1, e_out); end
            if (busy1 !== e_busy) begin failures++; $display("FAIL cont_retrig_busy cyc=%0d got=%0b exp=%0b", c, busy1, e_busy); end
            if (drop1 !== 1'b0)   begin failures++; $display("FAIL cont_retrig_drop cyc=%0d got=%0b exp=0", c, drop1); end
            next_cycle();
        end
    endtask

    // Hold from 10, dropped trigger at 11, rst with trigger at 12: cycle 13
    // fully cleared; a fresh pulse at 20 behaves like the single-pulse case.
    task automatic test_reset_abort();
        logic       e_out, e_busy, e_drop;
        logic [7:0] e_cnt;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            rst  = (c == 12);
            trig = (c == 10 || c == 11 || c == 12 || c == 20);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 12) || (c >= 21 && c <= 24);
            e_busy = (c >= 11 && c <= 12) || (c >= 21 && c <= 26);
            e_drop = (c == 12);
            e_cnt  = (c == 12) ? 8'd1 : 8'd0;
            checks = checks + 4;
            if (out0 !== e_out)   begin failures++; $display("FAIL abort_out cyc=%0d got=%0b exp=%0b", c, out0, e_out); end
            if (busy0 !== e_busy) begin failures++; $display("FAIL abort_busy cyc=%0d got=%0b exp=%0b", c, busy0, e_busy); end
            if (drop0 !== e_drop) begin failures++; $display("FAIL abort_drop cyc=%0d got=%0b exp=%0b", c, drop0, e_drop); end
            if (cnt0 !== e_cnt)   begin failures++; $display("FAIL abort_drop_cnt cyc=%0d got=%0d exp=%0d", c, cnt0, e_cnt); end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    // in high 10-359 on u0: IDLE cycles at 10+7k (k=0..49) accept, the other
    // 300 high cycles are dropped. drop_cnt must stop at 255.
    task automatic test_saturation();
        logic       e_out, e_drop;
        logic [7:0] e_cnt;
        do_reset();
        e_cnt = 8'd0;
        for (int c = 0; c <= 365; c++) begin
            trig = (c >= 10 && c <= 359);
            @(negedge clk);
            e_out  = (c >= 11 && c <= 357 && ((c - 11) % 7) < 4);
            e_drop = (c >= 11 && c <= 360 && ((c - 11) % 7) != 0);
            if (e_drop && e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
            checks = checks + 3;
            if (out0 !== e_out)   begin failures++; $display("FAIL sat_out cyc=%0d got=%0b exp=%0b", c, out0, e_out); end
            if (drop0 !== e_drop) begin failures++; $display("FAIL sat_drop cyc=%0d got=%0b exp=%0b", c, drop0, e_drop); end
            if (cnt0 !== e_cnt)   begin failures++; $display("FAIL sat_drop_cnt cyc=%0d got=%0d exp=%0d", c, cnt0, e_cnt); end
            next_cycle();
        end
        checks++;
        if (cnt0 !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", cnt0); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        trig     = 1'b0;
        test_reset();
        test_single();
        test_no_retrigger();
        test_retrigger();
        test_retrigger_last();
        test_continuous();
        test_continuous_retrig();
        test_reset_abort();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
